// File: rtl/pblaze_io_master_if.sv
// pblaze_io_master_if: host command/response channels plus Picoblaze port bus
interface pblaze_io_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       Wr_Strobe;
  logic       Rd_Strobe;
  logic [7:0] AddrOut;
  logic [7:0] DataOut;
  logic [7:0] DataIn;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, DataIn,
    output cmd_ready, rsp_valid, rsp_rdata, busy, Wr_Strobe, Rd_Strobe, AddrOut, DataOut
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, DataIn,
    input  cmd_ready, rsp_valid, rsp_rdata, busy, Wr_Strobe, Rd_Strobe, AddrOut, DataOut
  );
endinterface

// File: rtl/pblaze_io_master.sv
// pblaze_io_master: queued initiator generating Picoblaze port read/write cycles
module pblaze_io_master #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 1
) (
  input logic                 clk,
  input logic                 reset,
  pblaze_io_master_if.master  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RESP} state_t;
  state_t        state_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [16:0]   head;
  logic          push, pop, full;
  logic [2:0]    cnt_q;
  logic          is_wr_q, wr_stb_q, rd_stb_q, rsp_valid_q;
  logic [7:0]    addr_q, data_q, rdata_q;
  assign full = count_q == CW'(FIFO_DEPTH);
  assign push = bus.cmd_valid && !full;
  assign pop  = state_q == IDLE && count_q != '0 && !rsp_valid_q;
  assign head = mem[rd_ptr_q];
  // next queue pointers and occupancy from this cycle's push/pop
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (push ? CW'(1) : '0) - (pop ? CW'(1) : '0);
  end
  // queue bookkeeping; reset flushes every pending command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // queue storage: {write, addr, wdata}
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  end
  // port-cycle sequencer with registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          state_q <= SETUP;
          cnt_q   <= 3'(SETUP_CYCLES - 1);
          is_wr_q <= head[16];
          addr_q  <= head[15:8];
          if (head[16]) data_q <= head[7:0];
        end
        SETUP: if (cnt_q == '0) begin
          state_q  <= STROBE;
          wr_stb_q <= is_wr_q;
          rd_stb_q <= !is_wr_q;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
        STROBE: begin
          wr_stb_q <= 1'b0;
          rd_stb_q <= 1'b0;
          if (is_wr_q) begin
            state_q <= IDLE;
          end else begin
            rdata_q     <= bus.DataIn;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = count_q != '0 || state_q != IDLE || rsp_valid_q;
  assign bus.Wr_Strobe = wr_stb_q;
  assign bus.Rd_Strobe = rd_stb_q;
  assign bus.AddrOut   = addr_q;
  assign bus.DataOut   = data_q;
endmodule

// File: tb/tb_pblaze_io_master.sv
// tb_pblaze_io_master: scoreboard bench with register-file responder and directed timing cases
module tb_pblaze_io_master;
  localparam int SETUP_A = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;
  pblaze_io_master_if a_if ();
  pblaze_io_master_if b_if ();
  pblaze_io_master #(.FIFO_DEPTH(4), .SETUP_CYCLES(SETUP_A)) dut_a (.clk(clk), .reset(reset), .bus(a_if.master));
  pblaze_io_master #(.FIFO_DEPTH(4), .SETUP_CYCLES(3)) dut_b (.clk(clk), .reset(reset), .bus(b_if.master));
  typedef struct {logic w; logic [7:0] a; logic [7:0] d;} cyc_t;
  cyc_t       exp_cyc [$];
  logic [7:0] exp_rsp [$];
  int         wr_times [$];
  logic [7:0] ram [256];
  logic [7:0] model_mem [256];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       rsp_rand = 1'b0;
  logic       prev_stb = 1'b0, prev_rv = 1'b0, stb;
  logic [7:0] prev_addr = '0, prev_rd = '0, held;
  cyc_t       c;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction
  // reference model: commands execute in push order against a plain register array
  function automatic void model_push(logic w, logic [7:0] a, logic [7:0] d);
    exp_cyc.push_back('{w, a, d});
    if (w) model_mem[a] = d;
    else exp_rsp.push_back(model_mem[a]);
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // responder: register file with registered read data
  always @(posedge clk) begin
    if (a_if.Wr_Strobe) ram[a_if.AddrOut] <= a_if.DataOut;
    a_if.DataIn <= ram[a_if.AddrOut];
    b_if.DataIn <= b_if.AddrOut ^ 8'h5A;
  end
  always begin
    @(posedge clk);
    #1;
    if (rsp_rand) a_if.rsp_ready = 1'($urandom_range(0, 1));
  end
  // port-cycle monitor
  always @(negedge clk) begin
    if (reset) prev_stb = 1'b0;
    else begin
      stb = a_if.Wr_Strobe | a_if.Rd_Strobe;
      if (stb) begin
        chk("strobe_overlap", a_if.Wr_Strobe & a_if.Rd_Strobe, 0);
        chk("strobe_width", prev_stb, 0);
        chk("strobe_in_resp", a_if.rsp_valid, 0);
        chk("addr_stable", a_if.AddrOut, prev_addr);
        if (exp_cyc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobe at addr %0h expected none", a_if.AddrOut);
        end else begin
          c = exp_cyc.pop_front();
          chk("strobe_op", a_if.Wr_Strobe, c.w);
          chk("strobe_addr", a_if.AddrOut, c.a);
          if (c.w) chk("strobe_data", a_if.DataOut, c.d);
        end
        if (a_if.Wr_Strobe) wr_times.push_back(cyc);
      end
      prev_stb = stb;
      prev_addr = a_if.AddrOut;
    end
  end
  // response monitor
  always @(negedge clk) begin
    if (reset) prev_rv = 1'b0;
    else begin
      if (a_if.rsp_valid) begin
        if (prev_rv) chk("rsp_hold", a_if.rsp_rdata, prev_rd);
        if (a_if.rsp_ready) begin
          if (exp_rsp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got %0h expected none", a_if.rsp_rdata);
          end else chk("rsp_rdata", a_if.rsp_rdata, exp_rsp.pop_front());
        end
      end
      prev_rv = a_if.rsp_valid && !a_if.rsp_ready;
      prev_rd = a_if.rsp_rdata;
    end
  end
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    int t = 0;
    a_if.cmd_valid = 1'b1;
    a_if.cmd_write = w;
    a_if.cmd_addr  = a;
    a_if.cmd_wdata = d;
    @(negedge clk);
    while (!a_if.cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!a_if.cmd_ready) chk("send_timeout", a_if.cmd_ready, 1);
    else model_push(w, a, d);
    @(posedge clk);
    #1;
    a_if.cmd_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while ((a_if.busy || exp_cyc.size() != 0 || exp_rsp.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_busy", a_if.busy, 0);
    chk("drain_queues", exp_cyc.size() + exp_rsp.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'(i * 37 + 11);
      model_mem[i] = 8'(i * 37 + 11);
    end
    ram[3] = 8'h3C;
    model_mem[3] = 8'h3C;
    a_if.cmd_valid = 1'b0; a_if.cmd_write = 1'b0; a_if.cmd_addr = '0; a_if.cmd_wdata = '0; a_if.rsp_ready = 1'b0;
    b_if.cmd_valid = 1'b0; b_if.cmd_write = 1'b0; b_if.cmd_addr = '0; b_if.cmd_wdata = '0; b_if.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", a_if.cmd_ready, 1);
    chk("rst_rsp_valid", a_if.rsp_valid, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_strobes", {a_if.Wr_Strobe, a_if.Rd_Strobe}, 0);
    chk("rst_addr", a_if.AddrOut, 0);
    chk("rst_data", a_if.DataOut, 0);
    chk("rst_rdata", a_if.rsp_rdata, 0);
    chk("rst_b_ready", b_if.cmd_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    // single write: address/data for setup+strobe, one strobe cycle
    send(1'b1, 8'h07, 8'hA5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2 || k == 3) begin
        chk("wr_addr", a_if.AddrOut, 8'h07);
        chk("wr_data", a_if.DataOut, 8'hA5);
      end
      chk("wr_strobe_time", a_if.Wr_Strobe, k == 3);
      chk("wr_no_rsp", a_if.rsp_valid, 0);
    end
    chk("wr_busy_done", a_if.busy, 0);
    @(posedge clk);
    #1;
    // single read with host stalling the response one cycle
    send(1'b0, 8'h03, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("rd_strobe_time", a_if.Rd_Strobe, k == 3);
      chk("rd_valid_time", a_if.rsp_valid, k == 4);
    end
    chk("rd_rdata", a_if.rsp_rdata, 8'h3C);
    @(posedge clk);
    #1;
    a_if.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rd_valid_held", a_if.rsp_valid, 1);
    @(negedge clk);
    chk("rd_valid_clear", a_if.rsp_valid, 0);
    @(posedge clk);
    #1;
    // SETUP_CYCLES=3 read on the second instance
    b_if.cmd_valid = 1'b1;
    b_if.cmd_addr  = 8'h06;
    @(negedge clk);
    chk("b_ready", b_if.cmd_ready, 1);
    @(posedge clk);
    #1;
    b_if.cmd_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 5) chk("b_addr", b_if.AddrOut, 8'h06);
      chk("b_rd_strobe", b_if.Rd_Strobe, k == 5);
      chk("b_wr_strobe", b_if.Wr_Strobe, 0);
      chk("b_rsp_valid", b_if.rsp_valid, k == 6);
      if (k == 6) chk("b_rdata", b_if.rsp_rdata, 8'h5C);
    end
    chk("b_busy", b_if.busy, 0);
    @(posedge clk);
    #1;
    // pending response blocks a queued write
    a_if.rsp_ready = 1'b0;
    send(1'b0, 8'h05, 8'h00);
    send(1'b1, 8'h06, 8'h77);
    t = 0;
    while (!a_if.rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("blk_rsp_seen", a_if.rsp_valid, 1);
    held = a_if.rsp_rdata;
    repeat (5) begin
      @(negedge clk);
      chk("blk_no_wr", a_if.Wr_Strobe, 0);
      chk("blk_rdata", a_if.rsp_rdata, held);
    end
    @(posedge clk);
    #1;
    a_if.rsp_ready = 1'b1;
    drain();
    // fill the queue behind a stalled read, then release
    a_if.rsp_ready = 1'b0;
    send(1'b0, 8'h20, 8'h00);
    t = 0;
    while (!a_if.rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("full_rsp_seen", a_if.rsp_valid, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h30 + i), 8'($urandom));
    @(negedge clk);
    chk("full_ready", a_if.cmd_ready, 0);
    @(posedge clk);
    #1;
    wr_times.delete();
    fork
      send(1'b1, 8'h34, 8'($urandom));
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_hold", a_if.cmd_ready, 0);
        end
        @(posedge clk);
        #1;
        a_if.rsp_ready = 1'b1;
      end
    join
    t = 0;
    while (wr_times.size() < 5 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("full_wr_count", wr_times.size(), 5);
    for (int i = 1; i < 5 && i < wr_times.size(); i++)
      chk("wr_spacing", wr_times[i] - wr_times[i-1], SETUP_A + 2);
    drain();
    // reset during a strobe with two commands queued
    send(1'b1, 8'h40, 8'h11);
    send(1'b1, 8'h41, 8'h22);
    send(1'b1, 8'h42, 8'h33);
    @(negedge clk);
    chk("mid_strobe", a_if.Wr_Strobe, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_wr_strobe", a_if.Wr_Strobe, 0);
    chk("arst_ready", a_if.cmd_ready, 1);
    chk("arst_busy", a_if.busy, 0);
    chk("arst_addr", a_if.AddrOut, 0);
    exp_cyc.delete();
    exp_rsp.delete();
    #4;
    reset = 1'b0;
    model_mem = ram;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_quiet", {a_if.Wr_Strobe, a_if.Rd_Strobe, a_if.busy}, 0);
    end
    @(posedge clk);
    #1;
    // randomized traffic with random response back-pressure
    rsp_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
